// File: rtl/motor_sched_pkg.sv
// Shared encodings for the motor move scheduler: FSM states and travel-direction codes.
// No logic; imported by the scheduler top.
package motor_sched_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DEAD  = 3'd1;
    localparam logic [2:0] S_MOVE  = 3'd2;
    localparam logic [2:0] S_FIN   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_DN   = 2'd2;

    function automatic logic [1:0] dir_code(input logic up);
        return up ? DIR_UP : DIR_DN;
    endfunction

endpackage

// File: rtl/motor_rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, else lowest set request (wrap).
// Latency: combinational. Backpressure: none; the parent decides when a pick is taken.
// Pointer state is held by the parent.
module motor_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick_oh,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_any
);

    logic [N_REQ-1:0] req_hi;

    always_comb begin
        req_hi   = '0;
        pick_oh  = '0;
        pick_idx = '0;
        pick_any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            req_hi[i] = req[i] && (i >= int'(ptr));
        end
        // Upper half first gives the wrap-around search order starting at ptr.
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_any && req_hi[i]) begin
                pick_any    = 1'b1;
                pick_oh[i]  = 1'b1;
                pick_idx    = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_any && req[i]) begin
                pick_any    = 1'b1;
                pick_oh[i]  = 1'b1;
                pick_idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/motor_move_sched.sv
// Shares one up/down motor among N_REQ requesters (round-robin, dead time, timeout); MOTOR_SCHED_STATS_EN adds move/fault counters.
// Latency: grant and motor drive one cycle after a request is seen in IDLE; done one cycle after limit/cancel.
// Backpressure: requesters hold req until done; losers simply keep requesting, nothing is queued.
module motor_move_sched
    import motor_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DEAD_CYC    = 16,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_dir,
    input  logic             up_limit,
    input  logic             dn_limit,
    input  logic             fault_clr,
    output logic             motor_up_q,
    output logic             motor_dn_q,
    output logic [N_REQ-1:0] gnt,
    output logic             done,
    output logic             done_ok,
    output logic             fault
`ifdef MOTOR_SCHED_STATS_EN
    ,
    output logic [15:0]      stat_moves,
    output logic [15:0]      stat_faults
`endif
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [2:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             dir, dir_d;
    logic [1:0]       prev_dir, prev_d;
    logic [IDX_W-1:0] rr_ptr, ptr_d;
    logic [N_REQ-1:0] gnt_d;
    logic             ok_d;

    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             new_dir, new_lim, tgt_lim, cancel, sensor_bad;

    motor_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req      (req),
        .ptr      (rr_ptr),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    assign new_dir    = req_dir[pick_idx];
    assign new_lim    = new_dir ? up_limit : dn_limit;
    assign tgt_lim    = dir ? up_limit : dn_limit;
    assign cancel     = ~|(gnt & req);
    assign sensor_bad = up_limit & dn_limit;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        dir_d   = dir;
        prev_d  = prev_dir;
        ptr_d   = rr_ptr;
        gnt_d   = gnt;
        ok_d    = 1'b0;
        case (state)
            S_IDLE: begin
                gnt_d = '0;
                if (pick_any) begin
                    gnt_d = pick_oh;
                    ptr_d = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    dir_d = new_dir;
                    cnt_d = CNT_W'(1);
                    if (new_lim) begin
                        state_d = S_FIN;
                        ok_d    = 1'b1;
                    end else if (prev_dir != DIR_NONE && prev_dir != dir_code(new_dir)) begin
                        state_d = S_DEAD;
                    end else begin
                        state_d = S_MOVE;
                    end
                end
            end
            S_DEAD: begin
                if (sensor_bad) begin
                    state_d = S_FAULT;
                end else if (cancel) begin
                    state_d = S_FIN;
                    ok_d    = tgt_lim;
                end else if (cnt == CNT_W'(DEAD_CYC)) begin
                    state_d = S_MOVE;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_MOVE: begin
                // Reaching the limit outranks both cancel and timeout.
                if (sensor_bad) begin
                    state_d = S_FAULT;
                end else if (tgt_lim) begin
                    state_d = S_FIN;
                    ok_d    = 1'b1;
                end else if (cancel) begin
                    state_d = S_FIN;
                end else if (cnt == CNT_W'(TIMEOUT_CYC)) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_d = S_IDLE;
                    prev_d  = DIR_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
        if (state_d == S_FAULT) gnt_d = '0;
        if (state_d == S_MOVE)  prev_d = dir_code(dir_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            dir        <= 1'b0;
            prev_dir   <= DIR_NONE;
            rr_ptr     <= '0;
            gnt        <= '0;
            motor_up_q <= 1'b0;
            motor_dn_q <= 1'b0;
            done       <= 1'b0;
            done_ok    <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            dir        <= dir_d;
            prev_dir   <= prev_d;
            rr_ptr     <= ptr_d;
            gnt        <= gnt_d;
            motor_up_q <= (state_d == S_MOVE) & dir_d;
            motor_dn_q <= (state_d == S_MOVE) & ~dir_d;
            done       <= (state_d == S_FIN);
            done_ok    <= ok_d;
            fault      <= (state_d == S_FAULT);
        end
    end

`ifdef MOTOR_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_moves  <= '0;
            stat_faults <= '0;
        end else begin
            if (done && done_ok && stat_moves != 16'hFFFF)
                stat_moves <= stat_moves + 1'b1;
            if (state != S_FAULT && state_d == S_FAULT && stat_faults != 16'hFFFF)
                stat_faults <= stat_faults + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_motor_move_sched.sv
// Bench for motor_move_sched: directed scenarios with literal expectations plus random traffic,
// every cycle compared against a transaction-level model of the scheduler.
module tb_motor_move_sched;

    localparam int N       = 4;
    localparam int DEAD    = 16;
    localparam int TIMEOUT = 1024;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req, req_dir, gnt;
    logic         up_limit, dn_limit, fault_clr;
    logic         motor_up_q, motor_dn_q, done, done_ok, fault;
`ifdef MOTOR_SCHED_STATS_EN
    logic [15:0]  stat_moves, stat_faults;
`endif

    int checks = 0;
    int errors = 0;
    int mon_up = 0;
    int mon_dn = 0;

    motor_move_sched #(.N_REQ(N), .DEAD_CYC(DEAD), .TIMEOUT_CYC(TIMEOUT), .CNT_W(11)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_dir(req_dir),
        .up_limit(up_limit), .dn_limit(dn_limit), .fault_clr(fault_clr),
        .motor_up_q(motor_up_q), .motor_dn_q(motor_dn_q), .gnt(gnt),
        .done(done), .done_ok(done_ok), .fault(fault)
`ifdef MOTOR_SCHED_STATS_EN
        , .stat_moves(stat_moves), .stat_faults(stat_faults)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Transaction-level model: who holds the motor, how long it has run, what is owed next.
    int          m_idx = -1;
    bit          m_fin, m_ok, m_fault, m_dir;
    int          m_wait, m_run, m_ptr;
    int          m_last = -1;
    logic [15:0] m_moves, m_faults;

    task automatic model_fault();
        m_fault = 1'b1;
        m_idx   = -1;
        m_run   = 0;
        m_wait  = 0;
        if (m_faults != 16'hFFFF) m_faults = m_faults + 1'b1;
    endtask

    task automatic model_finish(input bit ok);
        m_fin  = 1'b1;
        m_ok   = ok;
        m_run  = 0;
        m_wait = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        int pick;
        bit found, tgt;
        if (!rst_n) begin
            m_idx = -1; m_fin = 0; m_ok = 0; m_fault = 0; m_dir = 0;
            m_wait = 0; m_run = 0; m_last = -1; m_ptr = 0;
            m_moves = '0; m_faults = '0;
        end else if (m_fault) begin
            if (fault_clr) begin
                m_fault = 1'b0;
                m_last  = -1;
            end
        end else if (m_fin) begin
            if (m_ok && m_moves != 16'hFFFF) m_moves = m_moves + 1'b1;
            m_fin = 0; m_ok = 0; m_idx = -1;
        end else if (m_idx < 0) begin
            if (req != '0) begin
                found = 0;
                pick  = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req[(m_ptr + k) % N]) begin
                        found = 1;
                        pick  = (m_ptr + k) % N;
                    end
                end
                m_idx = pick;
                m_ptr = (pick + 1) % N;
                m_dir = req_dir[pick];
                if (m_dir ? up_limit : dn_limit) model_finish(1'b1);
                else if (m_last >= 0 && m_last != int'(m_dir)) m_wait = DEAD;
                else begin
                    m_run  = 1;
                    m_last = int'(m_dir);
                end
            end
        end else begin
            tgt = m_dir ? up_limit : dn_limit;
            if (up_limit && dn_limit) model_fault();
            else if (m_wait > 0) begin
                if (!req[m_idx]) model_finish(tgt);
                else if (m_wait == 1) begin
                    m_wait = 0;
                    m_run  = 1;
                    m_last = int'(m_dir);
                end else m_wait--;
            end else begin
                if (tgt) model_finish(1'b1);
                else if (!req[m_idx]) model_finish(1'b0);
                else if (m_run == TIMEOUT) model_fault();
                else m_run++;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [N-1:0] eg;
        logic [63:0]  act, expv;
        eg = '0;
        if (m_idx >= 0) eg[m_idx] = 1'b1;
        act  = {55'd0, motor_up_q, motor_dn_q, gnt, done, done_ok, fault};
        expv = {55'd0, (m_run > 0) && m_dir, (m_run > 0) && !m_dir, eg, m_fin, m_fin && m_ok, m_fault};
`ifdef MOTOR_SCHED_STATS_EN
        act[63:32]  = {stat_moves, stat_faults};
        expv[63:32] = {m_moves, m_faults};
`endif
        check("cycle_outputs", act, expv);
        if (motor_up_q) mon_up++;
        if (motor_dn_q) mon_dn++;
    end

    // which: 0 motor_up_q, 1 motor_dn_q, 2 done, 3 fault, other gnt!=0
    task automatic wait_sig(input string name, input int which, input int max_cyc);
        bit hit;
        hit = 0;
        for (int k = 0; k < max_cyc && !hit; k++) begin
            @(negedge clk);
            case (which)
                0:       hit = motor_up_q;
                1:       hit = motor_dn_q;
                2:       hit = done;
                3:       hit = fault;
                default: hit = (gnt != '0);
            endcase
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: event not seen, waited %0d cycles", name, max_cyc);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [N-1:0] seq [5];
        int dead, rb;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        req = '0; req_dir = '0; up_limit = 0; dn_limit = 0; fault_clr = 0; rst_n = 0;
        repeat (3) @(negedge clk);
        check("reset_state", {motor_up_q, motor_dn_q, gnt, done, done_ok, fault}, '0);
        rst_n = 1;

        // All four requesting, each already at its limit: pure round-robin rotation.
        dn_limit = 1; req_dir = 4'b0000; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_sig("rr_done", 2, 10);
            check("rr_gnt", gnt, seq[k]);
            check("rr_ok", done_ok, 1);
            @(negedge clk);
            check("rr_gap", {gnt, done}, '0);
        end
        req = '0; dn_limit = 0;

        // Up travel for 10 cycles then limit.
        @(negedge clk);
        mon_up = 0; mon_dn = 0;
        req_dir = 4'b0001; req = 4'b0001;
        wait_sig("t1_move", 0, 5);
        check("t1_gnt", gnt, 4'b0001);
        repeat (9) @(negedge clk);
        up_limit = 1;
        @(negedge clk);
        check("t1_done", {done, done_ok, gnt, motor_up_q}, {1'b1, 1'b1, 4'b0001, 1'b0});
        check("t1_cycles", mon_up, 10);
        req = '0; up_limit = 0;

        // Same direction again, then a reversal that must wait out the dead time.
        @(negedge clk);
        req_dir = 4'b0010; req = 4'b0010;
        wait_sig("t2a_move", 0, 5);
        repeat (3) @(negedge clk);
        up_limit = 1;
        wait_sig("t2a_done", 2, 5);
        req = '0; up_limit = 0;
        @(negedge clk);
        req_dir = 4'b0000; req = 4'b0010;
        wait_sig("t2_gnt", 4, 5);
        dead = 0;
        for (int k = 0; k < 40 && !motor_dn_q; k++) begin
            if (!motor_up_q && gnt != '0) dead++;
            @(negedge clk);
        end
        check("t2_dead", dead, DEAD);
        check("t2_motor_dn", {motor_up_q, motor_dn_q, gnt}, {1'b0, 1'b1, 4'b0010});
        dn_limit = 1;
        wait_sig("t2_done", 2, 5);
        check("t2_ok", done_ok, 1);
        req = '0; dn_limit = 0;

        // No limit ever: timeout after exactly TIMEOUT motor cycles.
        @(negedge clk);
        mon_up = 0; mon_dn = 0;
        req_dir = 4'b0000; req = 4'b0100;
        wait_sig("t4_fault", 3, TIMEOUT + 50);
        check("t4_fault_out", {fault, motor_up_q, motor_dn_q, gnt, done}, {1'b1, 1'b0, 1'b0, 4'b0000, 1'b0});
        check("t4_cycles", mon_dn, TIMEOUT);
        req = 4'b0101;
        repeat (5) @(negedge clk);
        check("t4_ignored", {fault, gnt}, {1'b1, 4'b0000});
        req = '0; fault_clr = 1;
        @(negedge clk);
        fault_clr = 0;
        check("t4_clear", {fault, gnt}, '0);

        // Cancel mid-move, then a request already sitting at its limit.
        @(negedge clk);
        req_dir = 4'b1000; req = 4'b1000;
        wait_sig("t5_move", 0, 5);
        repeat (3) @(negedge clk);
        req = '0;
        @(negedge clk);
        check("t5_cancel", {motor_up_q, done, done_ok, gnt}, {1'b0, 1'b1, 1'b0, 4'b1000});
        @(negedge clk);
        mon_up = 0; mon_dn = 0;
        dn_limit = 1; req_dir = 4'b0000; req = 4'b1000;
        wait_sig("t5_done", 2, 5);
        check("t5_at_limit", {done_ok, gnt}, {1'b1, 4'b1000});
        check("t5_no_motion", mon_up + mon_dn, 0);
        req = '0; dn_limit = 0;

        // Both limits during travel, then asynchronous reset mid-move.
        @(negedge clk);
        req_dir = 4'b0001; req = 4'b0001;
        wait_sig("t6_move", 0, 5);
        up_limit = 1; dn_limit = 1;
        @(negedge clk);
        check("t6_sensor", {fault, motor_up_q, motor_dn_q, gnt}, {1'b1, 1'b0, 1'b0, 4'b0000});
        req = '0; up_limit = 0; dn_limit = 0; fault_clr = 1;
        @(negedge clk);
        fault_clr = 0;
        req_dir = 4'b0010; req = 4'b0010;
        wait_sig("t6_move2", 0, 5);
        #3 rst_n = 0;
        #1 check("t6_async_rst", {motor_up_q, motor_dn_q}, '0);
        req = '0;
        @(negedge clk);
        rst_n = 1;

        // Three good moves and one fault from a clean reset.
        dn_limit = 1; req_dir = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req = 4'b0001;
            wait_sig("st_done", 2, 5);
            req = '0;
        end
        @(negedge clk);
        dn_limit = 0; req_dir = 4'b0001; req = 4'b0001;
        wait_sig("st_move", 0, 5);
        up_limit = 1; dn_limit = 1;
        wait_sig("st_fault", 3, 5);
        req = '0; up_limit = 0; dn_limit = 0; fault_clr = 1;
        @(negedge clk);
        fault_clr = 0;
        @(negedge clk);
`ifdef MOTOR_SCHED_STATS_EN
        check("stats", {stat_moves, stat_faults}, {16'd3, 16'd1});
`endif

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) begin
                rb = $urandom_range(N - 1);
                req[rb] = ~req[rb];
            end
            if ($urandom_range(15) == 0) req_dir = N'($urandom);
            if ($urandom_range(19) == 0) up_limit = ~up_limit;
            if ($urandom_range(19) == 0) dn_limit = ~dn_limit;
            fault_clr = ($urandom_range(15) == 0);
        end
        req = '0; up_limit = 0; dn_limit = 0; fault_clr = 1;
        @(negedge clk);
        fault_clr = 0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
